// File: rtl/alu_exec.sv
// alu_exec: EX-stage ALU with single-cycle arithmetic/logic ops and iterative shifts behind valid/ready handshakes
module alu_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_decode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op;
  logic [5:0] cnt, step;
  logic [XLEN-1:0] res, alu_val, sh_val, sra_val;
  logic [4:0] shamt;
  logic ill, legal, is_shift, sh_start;
  assign shamt    = op_b[4:0];
  assign legal    = alu_decode <= 4'd8 || alu_decode == 4'd13;
  assign is_shift = alu_decode == 4'd1 || alu_decode == 4'd5 || alu_decode == 4'd13;
  assign sh_start = is_shift && shamt != 5'd0;
  assign step     = (cnt < 6'(SHIFT_STEP)) ? cnt : 6'(SHIFT_STEP);
  assign sra_val  = $signed(res) >>> step;
  assign sh_val   = op == 4'd1 ? res << step : op == 4'd5 ? res >> step : sra_val;
  // single-cycle result; shifts with zero shamt pass operand A through
  always_comb begin
    alu_val = '0;
    case (alu_decode)
      4'd0:                 alu_val = op_a + op_b;
      4'd1, 4'd5, 4'd13:    alu_val = op_a;
      4'd2:                 alu_val = XLEN'($signed(op_a) < $signed(op_b));
      4'd3:                 alu_val = XLEN'(op_a < op_b);
      4'd4:                 alu_val = op_a ^ op_b;
      4'd6:                 alu_val = op_a | op_b;
      4'd7:                 alu_val = op_a & op_b;
      4'd8:                 alu_val = op_a - op_b;
      default:              alu_val = '0;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state: a shift finishes when the remaining count fits in one step
  always_comb
    state_nx = state == IDLE  ? (in_valid ? (sh_start ? SHIFT : DONE) : IDLE) :
               state == SHIFT ? (cnt == step ? DONE : SHIFT) :
               (out_ready ? IDLE : DONE);
  // handshake outputs decoded from state
  always_comb begin
    in_ready  = state == IDLE;
    busy      = state != IDLE;
    out_valid = state == DONE;
  end
  // datapath: res doubles as the shift accumulator
  always_ff @(posedge clk)
    if (reset) begin
      res <= '0;
      ill <= 1'b0;
      cnt <= '0;
      op  <= '0;
    end else if (state == IDLE && in_valid) begin
      op  <= alu_decode;
      ill <= !legal;
      cnt <= {1'b0, shamt};
      res <= sh_start ? op_a : alu_val;
    end else if (state == SHIFT) begin
      res <= sh_val;
      cnt <= cnt - step;
    end
  assign result  = res;
  assign zero    = res == '0;
  assign illegal = ill;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: checks alu_exec at SHIFT_STEP 1 and 4 against an arithmetic reference model
module tb_alu_exec;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [3:0] alu_decode = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic ir1, ov1, z1, il1, b1, ir4, ov4, z4, il4, b4;
  logic [31:0] r1, r4;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(32), .SHIFT_STEP(1)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .alu_decode(alu_decode), .op_a(op_a), .op_b(op_b), .out_valid(ov1), .out_ready(out_ready),
    .result(r1), .zero(z1), .illegal(il1), .busy(b1));
  alu_exec #(.XLEN(32), .SHIFT_STEP(4)) u4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
    .alu_decode(alu_decode), .op_a(op_a), .op_b(op_b), .out_valid(ov4), .out_ready(out_ready),
    .result(r4), .zero(z4), .illegal(il4), .busy(b4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a << sh;
      4'd2:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return a - b;
      4'd13: return sa >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b, input int stp);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'd1 || op == 4'd5 || op == 4'd13) && sh != 0) return 1 + (sh + stp - 1) / stp;
    return 1;
  endfunction

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int c, l1, l4;
    logic [31:0] exp;
    logic ill;
    c = 0; l1 = 0; l4 = 0;
    exp = ref_res(op, a, b);
    ill = !(op <= 4'd8 || op == 4'd13);
    @(negedge clk);
    in_valid = 1; alu_decode = op; op_a = a; op_b = b;
    while ((l1 == 0 || l4 == 0) && c < 60) begin
      @(negedge clk);
      c++;
      if (ov1 && l1 == 0) l1 = c;
      if (ov4 && l4 == 0) l4 = c;
      alu_decode = 4'($urandom); op_a = $urandom; op_b = $urandom;
    end
    chk({tag, " lat1"}, 64'(l1), 64'(ref_lat(op, b, 1)));
    chk({tag, " lat4"}, 64'(l4), 64'(ref_lat(op, b, 4)));
    chk({tag, " res1"}, {r1, 31'd0, z1, il1}, {exp, 31'd0, exp == 0, ill});
    chk({tag, " res4"}, {r4, 31'd0, z4, il4}, {exp, 31'd0, exp == 0, ill});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {r1, r4}, {exp, exp});
      chk({tag, " hold_hs"}, {ir1, ir4, ov1, ov4, b1, b4}, 6'b001111);
    end
    out_ready = 1; in_valid = 0;
    @(negedge clk);
    out_ready = 0;
    chk({tag, " idle"}, {ir1, ir4, ov1, ov4, b1, b4}, 6'b110000);
  endtask

  initial begin
    logic [3:0] ops [11];
    logic [3:0] o;
    logic seen;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd15};
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset u1", {ir1, ov1, r1, z1, il1, b1}, {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0});
    chk("reset u4", {ir4, ov4, r4, z4, il4, b4}, {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0});
    run("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run("sub", 4'd8, 32'd5, 32'd7, 0);
    run("slt", 4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    run("sltu", 4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run("sra31", 4'd13, 32'h8000_0000, 32'd31, 0);
    run("srl31", 4'd5, 32'h8000_0000, 32'd31, 0);
    run("sll5", 4'd1, 32'd1, 32'h25, 0);
    run("sll0", 4'd1, 32'h1234_5678, 32'hFFFF_FFE0, 0);
    run("hold10", 4'd4, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 10);
    run("illegal", 4'd15, 32'h1234, 32'h5678, 0);
    for (int i = 0; i < 30; i++) begin
      o = ops[$urandom_range(0, 10)];
      run("rand", o, $urandom, $urandom, 0);
    end
    @(negedge clk);
    in_valid = 1; alu_decode = 4'd5; op_a = $urandom; op_b = 32'd20;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("abort busy", {b1, b4, ov1, ov4}, 4'b1100);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort u1", {ir1, ov1, r1, z1, il1, b1}, {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0});
    chk("abort u4", {ir4, ov4, r4, z4, il4, b4}, {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0});
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | ov1 | ov4;
    end
    chk("abort no_valid", 64'(seen), 64'd0);
    run("after_abort", 4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
